div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
Iterative sequencer for the EX-stage divider. It drives one controlled add/subtract row per cycle, using the non-restoring algorithm, over a WIDTH+1-bit partial remainder. It handles signed and unsigned DIV/REM operands, divide-by-zero and signed overflow, a start/busy/done handshake with the EX stage, and a pipeline flush. Quotient and remainder are produced together; the EX stage selects which one to use.

Parameters:
WIDTH, 32, operand/result width in bits; must be at least 2.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  pipeline flush; abandons any operation in flight
start  input  1  request new division; sampled only when busy=0
is_signed  input  1  1 = two's-complement operands (DIV/REM), 0 = unsigned (DIVU/REMU)
dividend  input  WIDTH  dividend, sampled with accepted start
divisor  input  WIDTH  divisor, sampled with accepted start
busy  output  1  operation in progress; high in PREP, ITER, FIX
done  output  1  one-cycle pulse, quotient/remainder valid
quotient  output  WIDTH  result quotient, held until next accepted start
remainder  output  WIDTH  result remainder, held until next accepted start

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE. busy=0, done=0, quotient=0, remainder=0. Counter and internal registers are cleared. rst overrides flush and start.
- Synchronous, active-high rst only; no asynchronous paths.

States:
- IDLE: wait for start.
- PREP: special-case check and operand conditioning.
- ITER: one row per cycle, WIDTH cycles.
- FIX: remainder correction and sign fixup.
- DONE: results valid.

Transitions:
- Accept: start=1 while busy=0 (IDLE or DONE) and flush=0.
  - Latch operands and is_signed.
  - Go to PREP.
  - quotient/remainder keep their old values until overwritten in DONE.
- PREP, divisor==0: set quotient=all ones, remainder=dividend (raw, unmodified); go to DONE.
- PREP, is_signed & dividend==MIN & divisor==all ones: set quotient=MIN (1 followed by WIDTH-1 zeros), remainder=0; go to DONE.
- PREP, otherwise:
  - Store magnitudes: |a|, |d| when is_signed, raw values when unsigned.
  - Record neg_q = sign(a) XOR sign(d) and neg_r = sign(a); both are 0 when unsigned.
  - Set P=0 (WIDTH+1 bits, signed), Q=|a|, count=0; go to ITER.
  - |MIN| is represented correctly because operands are treated as unsigned WIDTH-bit magnitudes.
- ITER, each cycle:
  - Shift {P,Q} left by 1.
  - If old P >= 0 then P = P_shift - |d|, else P = P_shift + |d|.
  - New Q LSB = NOT sign(new P).
  - count++.
  - After count reaches WIDTH-1 in ITER (i.e. WIDTH iterations), go to FIX.
- FIX:
  - If P < 0 then R = P + |d|, else R = P.
  - quotient = neg_q ? -Q : Q.
  - remainder = neg_r ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next state: PREP if an accepted start is present this cycle (back-to-back), else IDLE.

Latency and handshake:
- Start cycle = cycle 0.
- Normal path: done at cycle WIDTH+3 (35 for WIDTH=32).
- Special cases: done at cycle 2.
- start while busy=1 is ignored; no queueing.
- Inputs need only be valid in the start cycle.

Flush:
- flush=1 in any state: next state=IDLE, done not asserted, busy=0 next cycle.
- Outputs keep their last valid values.
- flush wins over a simultaneous start.
- flush in the DONE cycle does not suppress that cycle's done, because done is already registered; the next state is IDLE.

Arithmetic:
- All P operations are WIDTH+1 bits wide.
- Negation is two's complement modulo 2^WIDTH.

Test Plan:
- Unsigned 100 / 7 -> done at cycle 35, quotient=14, remainder=2; busy high cycles 1-34, low at cycle 35.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero: 5 / 0, both signed and unsigned -> done at cycle 2, quotient=0xFFFFFFFF, remainder=5.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> done at cycle 2, quotient=0x80000000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x80000000 at cycle 35.
- flush at cycle 10 of 100/7 -> busy=0 at cycle 11, no done pulse. Then start 9/3 -> quotient=3, remainder=0, 35 cycles later.
- start pulsed at cycle 5 of a busy op -> ignored, result unaffected. start in the DONE cycle with 0xFFFFFFFF/1 unsigned -> accepted, quotient=0xFFFFFFFF, remainder=0. rst asserted mid-op -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Non-restoring iterative divider sequencer for the EX stage.
// Produces quotient and remainder together for signed/unsigned operands.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2:0]       r_state;
  // r_q/r_d hold the raw operands until PREP, then the magnitudes
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sgn;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic             w_a_neg;
  logic             w_d_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_d_mag;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_p_next;
  logic [WIDTH:0]   w_r_fix;

  always_comb begin
    w_a_neg   = r_sgn & r_q[WIDTH-1];
    w_d_neg   = r_sgn & r_d[WIDTH-1];
    w_a_mag   = w_a_neg ? -r_q : r_q;
    w_d_mag   = w_d_neg ? -r_d : r_d;
    w_div0    = (r_d == '0);
    w_ovf     = r_sgn & (r_q == MIN_VAL) & (r_d == '1);
    w_d_ext   = {1'b0, r_d};
    w_p_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    // Sign of the old partial remainder selects add or subtract
    w_p_next  = r_p[WIDTH] ? (w_p_shift + w_d_ext) : (w_p_shift - w_d_ext);
    w_r_fix   = r_p[WIDTH] ? (r_p + w_d_ext) : r_p;
  end

  assign busy      = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_quot;
  assign remainder = r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_q     <= dividend;
            r_d     <= divisor;
            r_sgn   <= is_signed;
            r_state <= S_PREP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PREP: begin
          if (w_div0) begin
            r_quot  <= '1;
            r_rem   <= r_q;
            r_state <= S_DONE;
          end else if (w_ovf) begin
            r_quot  <= MIN_VAL;
            r_rem   <= '0;
            r_state <= S_DONE;
          end else begin
            r_q     <= w_a_mag;
            r_d     <= w_d_mag;
            r_neg_q <= w_a_neg ^ w_d_neg;
            r_neg_r <= w_a_neg;
            r_p     <= '0;
            r_cnt   <= '0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_p   <= w_p_next;
          r_q   <= {r_q[WIDTH-2:0], ~w_p_next[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_state <= S_FIX;
        end
        S_FIX: begin
          r_quot  <= r_neg_q ? -r_q : r_q;
          r_rem   <= r_neg_r ? -w_r_fix[WIDTH-1:0] : w_r_fix[WIDTH-1:0];
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed plan cases plus random
// operands checked against an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Reference: truncating division as defined for DIV/DIVU/REM/REMU
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] d,
                                  input bit s, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output int lat);
    longint sa, sd, tq, tr;
    if (d == '0) begin
      q = '1; r = a; lat = 2;
    end else if (s && a == MINV && d == '1) begin
      q = MINV; r = '0; lat = 2;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sd = longint'($signed(d));
      end else begin
        sa = longint'({32'd0, a});
        sd = longint'({32'd0, d});
      end
      tq = sa / sd;
      tr = sa % sd;
      q = tq[W-1:0];
      r = tr[W-1:0];
      lat = W + 3;
    end
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] d, input bit s);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = d; is_signed = s;
  endtask

  // Waits for done after a start in cycle 0; optionally pulses start at inj_cycle.
  task automatic wait_done(input int inj_cycle, input logic [W-1:0] ia,
                           input logic [W-1:0] id, input bit is_,
                           output int lat, output int busy_hi, output bit busy_at_done);
    lat = -1; busy_hi = 0; busy_at_done = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n; busy_at_done = busy;
        break;
      end
      if (busy) busy_hi++;
      if (n == inj_cycle) begin
        start = 1'b1; dividend = ia; divisor = id; is_signed = is_;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quot: got %h expected 0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_rem: got %h expected 0", remainder); end
  endtask

  typedef struct packed {
    logic [W-1:0] a; logic [W-1:0] d; logic s;
    logic [W-1:0] q; logic [W-1:0] r; int lat;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[7];
    int lat, bh; bit bd;
    tbl[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 35};
    tbl[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35};
    tbl[2] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 35};
    tbl[3] = '{32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 2};
    tbl[4] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 2};
    tbl[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 2};
    tbl[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 35};
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].a, tbl[i].d, tbl[i].s);
      wait_done(0, '0, '0, 1'b0, lat, bh, bd);
      n_checks++; if (lat != tbl[i].lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
      n_checks++; if (quotient !== tbl[i].q) begin n_fail++; $display("FAIL dir%0d_quot: got %h expected %h", i, quotient, tbl[i].q); end
      n_checks++; if (remainder !== tbl[i].r) begin n_fail++; $display("FAIL dir%0d_rem: got %h expected %h", i, remainder, tbl[i].r); end
      n_checks++; if (bh != tbl[i].lat - 1 || bd !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy: got %0d high cycles, %b at done expected %0d, 0", i, bh, bd, tbl[i].lat - 1); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done); end
      n_checks++; if (quotient !== tbl[i].q) begin n_fail++; $display("FAIL dir%0d_quot_hold: got %h expected %h", i, quotient, tbl[i].q); end
      last_q = tbl[i].q; last_r = tbl[i].r;
    end
  endtask

  task automatic test_flush();
    int lat, bh, ndone; bit bd;
    issue(32'd100, 32'd7, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", ndone); end
    n_checks++; if (quotient !== last_q || remainder !== last_r) begin n_fail++; $display("FAIL flush_hold: got %h/%h expected %h/%h", quotient, remainder, last_q, last_r); end
    issue(32'd9, 32'd3, 1'b0);
    wait_done(0, '0, '0, 1'b0, lat, bh, bd);
    n_checks++; if (lat != 35) begin n_fail++; $display("FAIL flush_next_latency: got %0d expected 35", lat); end
    n_checks++; if (quotient !== 32'd3 || remainder !== 32'd0) begin n_fail++; $display("FAIL flush_next_result: got %h/%h expected 3/0", quotient, remainder); end
    last_q = 32'd3; last_r = 32'd0;
  endtask

  task automatic test_busy_start();
    int lat, bh; bit bd;
    issue(32'd1000, 32'd10, 1'b0);
    wait_done(5, 32'h1234_5678, 32'd3, 1'b1, lat, bh, bd);
    n_checks++; if (lat != 35) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 35", lat); end
    n_checks++; if (quotient !== 32'd100 || remainder !== 32'd0) begin n_fail++; $display("FAIL busy_start_result: got %h/%h expected 64/0", quotient, remainder); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL busy_start_no_queue: got busy %b done %b expected 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int lat, bh; bit bd;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(0, '0, '0, 1'b0, lat, bh, bd);
    n_checks++; if (lat != 35 || quotient !== 32'd14) begin n_fail++; $display("FAIL b2b_first: got lat %0d quot %h expected 35, e", lat, quotient); end
    start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'd1; is_signed = 1'b0;
    wait_done(0, '0, '0, 1'b0, lat, bh, bd);
    n_checks++; if (lat != 35) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 35", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_result: got %h/%h expected ffffffff/0", quotient, remainder); end
  endtask

  task automatic test_mid_reset();
    issue(32'd12345, 32'd17, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got busy %b done %b expected 0 0", busy, done); end
    n_checks++; if (quotient !== '0 || remainder !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h/%h expected 0/0", quotient, remainder); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, d, eq, er;
    bit s;
    int elat, lat, bh; bit bd;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; d = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: d = '0;
        1: begin a = MINV; d = '1; end
        2: d = 32'($urandom_range(1, 20));
        3: a = MINV;
        4: d = '1;
        5: d = d >> $urandom_range(0, 31);
        default: ;
      endcase
      ref_div(a, d, s, eq, er, elat);
      issue(a, d, s);
      wait_done(0, '0, '0, 1'b0, lat, bh, bd);
      n_checks++; if (lat != elat) begin n_fail++; $display("FAIL rnd%0d_latency (%h/%h s=%b): got %0d expected %0d", i, a, d, s, lat, elat); end
      n_checks++; if (quotient !== eq) begin n_fail++; $display("FAIL rnd%0d_quot (%h/%h s=%b): got %h expected %h", i, a, d, s, quotient, eq); end
      n_checks++; if (remainder !== er) begin n_fail++; $display("FAIL rnd%0d_rem (%h/%h s=%b): got %h expected %h", i, a, d, s, remainder, er); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
